// File: rtl/data_loader_buffered.sv
// Purpose: queue APF bridge writes that hit the address window, then replay each word as 1/2/4-byte chunks.
// Latency: a bridge write accepted in cycle 0 with the block idle and ready asserted gives write_en in cycle 3.
// Backpressure: write_ready low stalls chunk issue; matching writes arriving while the FIFO is full are dropped (sticky flag).
//
// Ports:
//   clk_74a, reset_n                     bridge clock, async active-low reset
//   bridge_wr/addr/wr_data/endian_little bridge write side
//   write_ready                          sink can take a chunk this cycle
//   write_en/addr/data                   registered chunk write, one-cycle strobe
//   busy                                 FIFO non-empty or a word is being emitted
//   fifo_overflow                        sticky: a matching write was dropped
`timescale 1ns/1ps

// Generic FIFO: registered storage, head visible combinationally, no flags beyond empty/full.
// Latency: pushed data is visible at the head on the cycle after the push.
// Backpressure: caller must not push when full or pop when empty.
module data_loader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: emptiness is defined purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= push_dat;
  end

  assign head_dat = mem[rd_ptr[PW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
endmodule

module data_loader_buffered #(
  parameter logic [3:0] ADDRESS_MASK_UPPER_4 = 4'h1,
  parameter int         ADDRESS_SIZE         = 14,
  parameter int         OUTPUT_WORD_SIZE     = 1,   // 1, 2 or 4 bytes
  parameter int         WRITE_DELAY          = 10,  // 0..255 idle cycles between strobes
  parameter int         FIFO_DEPTH           = 4    // power of 2, >= 2
) (
  input  logic                          clk_74a,
  input  logic                          reset_n,
  input  logic                          bridge_wr,
  input  logic                          bridge_endian_little,
  input  logic [31:0]                   bridge_addr,
  input  logic [31:0]                   bridge_wr_data,
  input  logic                          write_ready,
  output logic                          write_en,
  output logic [ADDRESS_SIZE:0]         write_addr,
  output logic [8*OUTPUT_WORD_SIZE-1:0] write_data,
  output logic                          busy,
  output logic                          fifo_overflow
);
  localparam int AW = ADDRESS_SIZE + 1;
  localparam int DW = 8 * OUTPUT_WORD_SIZE;
  localparam int N  = 4 / OUTPUT_WORD_SIZE;
  localparam int EW = AW + 32;

  localparam logic [1:0] LAST_K   = 2'(N - 1);
  localparam logic [7:0] DELAY_LD = 8'(WRITE_DELAY);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t        state;
  logic [1:0]    k;            // chunk index within the cached word
  logic [7:0]    delay_cnt;
  logic [AW-1:0] base_addr;
  logic [31:0]   cache_word;   // little-endian normalised word being emitted

  logic          match;
  logic [31:0]   norm_data;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [EW-1:0] fifo_head;
  logic [AW-1:0] head_addr;
  logic [31:0]   head_word;
  logic          issue;
  logic          last_chunk;
  logic [3:0]    chunk_off;
  logic [AW-1:0] chunk_addr;
  logic [31:0]   chunk_shifted;
  logic [DW-1:0] chunk_data;
  logic          unused_bits;

  assign match = bridge_wr && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);

  // Big-endian bridge data is byte-reversed so chunk 0 always holds the lowest-address byte(s).
  always_comb begin
    norm_data = bridge_wr_data;
    if (!bridge_endian_little) begin
      norm_data = {bridge_wr_data[7:0], bridge_wr_data[15:8],
                   bridge_wr_data[23:16], bridge_wr_data[31:24]};
    end
  end

  // Full is judged before any same-cycle pop, so a write racing a pop into a full FIFO is still dropped.
  assign fifo_push = match && !fifo_full;

  data_loader_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_74a),
    .rst_n    (reset_n),
    .push     (fifo_push),
    .push_dat ({bridge_addr[ADDRESS_SIZE:0], norm_data}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign head_addr = fifo_head[EW-1:32];
  assign head_word = fifo_head[31:0];

  assign issue      = (state == EMIT) && (delay_cnt == 8'd0) && write_ready;
  assign last_chunk = (k == LAST_K);

  // Pop on entry from IDLE, or chain straight into the next word when the last chunk issues.
  assign fifo_pop = !fifo_empty && ((state == IDLE) || (issue && last_chunk));

  // Byte offset of chunk k; address arithmetic wraps at the write_addr width.
  assign chunk_off     = 4'(k) * 4'(OUTPUT_WORD_SIZE);
  assign chunk_addr    = base_addr + AW'(chunk_off);
  assign chunk_shifted = cache_word >> {chunk_off, 3'b000};
  assign chunk_data    = chunk_shifted[DW-1:0];

  assign busy = !fifo_empty || (state != IDLE);

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      k             <= 2'd0;
      delay_cnt     <= 8'd0;
      base_addr     <= '0;
      cache_word    <= 32'd0;
      write_en      <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      write_en <= 1'b0;

      if (match && fifo_full) fifo_overflow <= 1'b1;

      if (delay_cnt != 8'd0) delay_cnt <= delay_cnt - 8'd1;

      case (state)
        IDLE: begin
          if (fifo_pop) begin
            base_addr  <= head_addr;
            cache_word <= head_word;
            k          <= 2'd0;
            state      <= EMIT;
          end
        end
        EMIT: begin
          // issue already implies delay_cnt == 0, so this reload never races the decrement.
          if (issue) begin
            write_en   <= 1'b1;
            write_addr <= chunk_addr;
            write_data <= chunk_data;
            delay_cnt  <= DELAY_LD;
            if (!last_chunk) begin
              k <= k + 2'd1;
            end else if (fifo_pop) begin
              base_addr  <= head_addr;
              cache_word <= head_word;
              k          <= 2'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  // Address bits outside the window and chunk bits above the output width are intentionally unused.
  assign unused_bits = ^{bridge_addr, chunk_shifted};
endmodule
